huffman_coder_mc: RTL and testbench

Parametrised multi-component JPEG Huffman entropy coder, the next generation of the single-configuration `huffman` block. It reads one 8x8 block of zig-zag-ordered quantised coefficients from the coefficient RAM and keeps a DC predictor per component. It forms DC-difference, run/size, ZRL and EOB symbols, looks each one up in an external code table, and emits right-justified variable-length words to the bit packer over a valid/ready handshake.

---
 rtl/huffman_coder_mc.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_huffman_coder_mc.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_coder_mc.sv
// Multi-component JPEG Huffman entropy coder: one 8x8 zig-zag block in, right-justified {code, amplitude} words out.
// Optional HUFF_RESTART_EN adds restart_in, which clears the per-component DC predictors.
module huffman_coder_mc #(
    parameter int               COEF_W  = 12,
    parameter int               NCH     = 3,
    parameter logic [NCH-1:0]   TBL_MAP = 3'b110
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          comp_id,
    input  logic [5:0]          max_not_zero_idx,
    input  logic                eof_in,
    input  logic                zig_zag_halt,
`ifdef HUFF_RESTART_EN
    input  logic                restart_in,
`endif
    output logic                ram_rd,
    output logic [5:0]          ram_addr,
    input  logic [COEF_W-1:0]   ram_d_in,
    output logic                tbl_rd,
    output logic                tbl_ac,
    output logic                tbl_sel,
    output logic [7:0]          tbl_addr,
    input  logic [15:0]         tbl_code,
    input  logic [4:0]          tbl_len,
    output logic [31:0]         d_out,
    output logic [5:0]          d_len,
    output logic                d_qual,
    input  logic                d_ready,
    output logic                eof_out,
    output logic                busy
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | issue coefficient read at idx (held while zig_zag_halt)
    // EVAL  | classify coefficient, compute size/amplitude, pick table address
    // ZRL   | look up the zero-run-length code (0xF0)
    // LOOK  | look up the DC/AC code chosen in EVAL
    // FORM  | register {code, amplitude} and length
    // EMIT  | hold d_qual until d_ready
    // EOB   | look up the end-of-block code (AC 0x00)

    localparam int AW = COEF_W + 1;

    typedef enum logic [2:0] {IDLE, READ, EVAL, ZRL, LOOK, FORM, EMIT, EOB} state_t;
    typedef enum logic [1:0] {K_DATA, K_ZRL, K_EOB} kind_t;

    state_t                 state, state_nx;
    kind_t                  kind;
    logic [5:0]             idx, run, last;
    logic [1:0]             comp;
    logic                   eof_lat;
    logic [4:0]             size_r;
    logic [AW-1:0]          amp_r;
    logic                   tbl_ac_r;
    logic [7:0]             tbl_addr_r;
    logic [31:0]            d_out_r;
    logic [5:0]             d_len_r;
    logic                   eof_r;
    logic [COEF_W-1:0]      pred [NCH];

    logic [COEF_W-1:0]      pred_cur;
    logic                   map_bit;
    logic                   is_dc, coef_zero, idx_last, final_word, block_end, clear_all;
    logic [AW-1:0]          coef_ext, pred_ext, val, mag, mask, amp_c;
    logic [4:0]             size_c;

    always_comb begin
        pred_cur = '0;
        map_bit  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (comp == 2'(i)) begin
                pred_cur = pred[i];
                map_bit  = TBL_MAP[i];
            end
        end
    end

    // DC codes the difference against the predictor, AC codes the coefficient itself.
    always_comb begin
        is_dc     = (idx == 6'd0);
        coef_zero = (ram_d_in == '0);
        coef_ext  = {ram_d_in[COEF_W-1], ram_d_in};
        pred_ext  = {pred_cur[COEF_W-1], pred_cur};
        val       = is_dc ? (coef_ext - pred_ext) : coef_ext;
        mag       = val[AW-1] ? (~val + AW'(1)) : val;
        size_c    = 5'd0;
        for (int b = 0; b < AW; b++) begin
            if (mag[b]) begin
                size_c = 5'(b + 1);
            end
        end
        mask  = (AW'(1) << size_c) - AW'(1);
        amp_c = (val[AW-1] ? (val - AW'(1)) : val) & mask;
    end

    assign idx_last   = (idx == last);
    assign final_word = (kind == K_EOB) || ((kind == K_DATA) && idx_last && (last == 6'd63));
    assign block_end  = (state == EMIT) && d_ready && final_word;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ram_rd   = 1'b0;
        ram_addr = 6'd0;
        tbl_rd   = 1'b0;
        tbl_ac   = 1'b0;
        tbl_addr = 8'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = READ;
                end
            end
            READ: begin
                ram_addr = idx;
                if (!zig_zag_halt) begin
                    ram_rd   = 1'b1;
                    state_nx = EVAL;
                end
            end
            EVAL: begin
                if (is_dc) begin
                    state_nx = LOOK;
                end else if (coef_zero) begin
                    state_nx = idx_last ? EOB : READ;
                end else if (run > 6'd15) begin
                    state_nx = ZRL;
                end else begin
                    state_nx = LOOK;
                end
            end
            ZRL: begin
                tbl_rd   = 1'b1;
                tbl_ac   = 1'b1;
                tbl_addr = 8'hF0;
                state_nx = FORM;
            end
            LOOK: begin
                tbl_rd   = 1'b1;
                tbl_ac   = tbl_ac_r;
                tbl_addr = tbl_addr_r;
                state_nx = FORM;
            end
            EOB: begin
                tbl_rd   = 1'b1;
                tbl_ac   = 1'b1;
                tbl_addr = 8'h00;
                state_nx = FORM;
            end
            FORM: begin
                state_nx = EMIT;
            end
            EMIT: begin
                if (d_ready) begin
                    case (kind)
                        K_ZRL:   state_nx = READ;
                        K_EOB:   state_nx = IDLE;
                        default: begin
                            if (!idx_last) begin
                                state_nx = READ;
                            end else begin
                                state_nx = (last == 6'd63) ? IDLE : EOB;
                            end
                        end
                    endcase
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign tbl_sel = tbl_rd & map_bit;
    assign d_out   = d_out_r;
    assign d_len   = d_len_r;
    assign d_qual  = (state == EMIT);
    assign eof_out = eof_r & d_qual;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            kind       <= K_DATA;
            idx        <= 6'd0;
            run        <= 6'd0;
            last       <= 6'd0;
            comp       <= 2'd0;
            eof_lat    <= 1'b0;
            size_r     <= 5'd0;
            amp_r      <= '0;
            tbl_ac_r   <= 1'b0;
            tbl_addr_r <= 8'd0;
            d_out_r    <= 32'd0;
            d_len_r    <= 6'd0;
            eof_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        comp    <= comp_id;
                        last    <= max_not_zero_idx;
                        eof_lat <= eof_in;
                        idx     <= 6'd0;
                        run     <= 6'd0;
                    end
                end
                EVAL: begin
                    kind       <= K_DATA;
                    size_r     <= size_c;
                    amp_r      <= amp_c;
                    tbl_ac_r   <= !is_dc;
                    tbl_addr_r <= is_dc ? {3'b000, size_c} : {run[3:0], size_c[3:0]};
                    if (!is_dc && coef_zero && !idx_last) begin
                        run <= run + 6'd1;
                        idx <= idx + 6'd1;
                    end
                end
                ZRL, EOB: begin
                    kind   <= (state == ZRL) ? K_ZRL : K_EOB;
                    size_r <= 5'd0;
                    amp_r  <= '0;
                end
                FORM: begin
                    d_out_r <= (32'(tbl_code) << size_r) | 32'(amp_r);
                    d_len_r <= 6'(tbl_len) + 6'(size_r);
                    eof_r   <= eof_lat & final_word;
                end
                EMIT: begin
                    if (d_ready) begin
                        if (kind == K_ZRL) begin
                            run <= run - 6'd16;
                        end else if (kind == K_DATA) begin
                            run <= 6'd0;
                            if (!idx_last) begin
                                idx <= idx + 6'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HUFF_RESTART_EN
    logic restart_pend;

    // A restart seen mid-block waits for the block to finish so its DC coding stays consistent.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            restart_pend <= 1'b0;
        end else if (block_end) begin
            restart_pend <= 1'b0;
        end else if (restart_in && (state != IDLE)) begin
            restart_pend <= 1'b1;
        end
    end

    assign clear_all = (block_end && (eof_lat || restart_pend || restart_in)) ||
                       (restart_in && (state == IDLE));
`else
    assign clear_all = block_end && eof_lat;
`endif

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                pred[i] <= '0;
            end
        end else if (clear_all) begin
            for (int i = 0; i < NCH; i++) begin
                pred[i] <= '0;
            end
        end else if ((state == EVAL) && is_dc) begin
            for (int i = 0; i < NCH; i++) begin
                if (comp == 2'(i)) begin
                    pred[i] <= ram_d_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_huffman_coder_mc.sv
// Randomized self-checking bench for huffman_coder_mc against a block-level JPEG symbol model.
module tb_huffman_coder_mc;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  comp_id = 2'd0;
    logic [5:0]  max_idx = 6'd0;
    logic        eof_in = 1'b0;
    logic        zig_zag_halt;
    logic        halt_force = 1'b0, halt_rand = 1'b0, halt_rnd = 1'b0;
    logic        d_ready;
    logic        ready_force = 1'b1, ready_rand = 1'b0, ready_rnd = 1'b1;
`ifdef HUFF_RESTART_EN
    logic        restart_in = 1'b0;
`endif
    logic        ram_rd, tbl_rd, tbl_ac, tbl_sel, d_qual, eof_out, busy;
    logic [5:0]  ram_addr, d_len;
    logic [7:0]  tbl_addr;
    logic [11:0] ram_d_in = '0;
    logic [15:0] tbl_code = '0;
    logic [4:0]  tbl_len = '0;
    logic [31:0] d_out;

    logic signed [11:0] mem [64];
    logic [38:0]        got_q [$];
    logic [38:0]        exp_q [$];
    logic               last_sel = 1'b0;
    int                 pred_m [3];
    int                 checks = 0;
    int                 errors = 0;

    assign zig_zag_halt = halt_force | (halt_rand & halt_rnd);
    assign d_ready      = ready_rand ? ready_rnd : ready_force;

    always #5 clk_in = ~clk_in;

    huffman_coder_mc dut (
        .clk_in(clk_in), .rst(rst), .start(start), .comp_id(comp_id),
        .max_not_zero_idx(max_idx), .eof_in(eof_in), .zig_zag_halt(zig_zag_halt),
`ifdef HUFF_RESTART_EN
        .restart_in(restart_in),
`endif
        .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_d_in(ram_d_in),
        .tbl_rd(tbl_rd), .tbl_ac(tbl_ac), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr),
        .tbl_code(tbl_code), .tbl_len(tbl_len),
        .d_out(d_out), .d_len(d_len), .d_qual(d_qual), .d_ready(d_ready),
        .eof_out(eof_out), .busy(busy)
    );

    // Synthetic code table: length 1..16, code fits its length, distinct per table/address.
    function automatic logic [20:0] tbl_f(input logic ac, input logic sel, input logic [7:0] a);
        int unsigned h, l;
        h = 32'(a) * 37 + (ac ? 101 : 0) + (sel ? 59 : 0) + 13;
        l = (h % 16) + 1;
        return {5'(l), 16'((h * 7919) & ((32'd1 << l) - 1))};
    endfunction

    always @(posedge clk_in) begin
        if (ram_rd) ram_d_in <= mem[ram_addr];
        if (tbl_rd) {tbl_len, tbl_code} <= tbl_f(tbl_ac, tbl_sel, tbl_addr);
    end

    always @(negedge clk_in) begin
        if (d_qual && d_ready) got_q.push_back({eof_out, d_len, d_out});
        if (tbl_rd) last_sel <= tbl_sel;
    end

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            halt_rnd  = ($urandom_range(0, 3) == 0);
            ready_rnd = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    function automatic int bitlen(input int m);
        int s = 0;
        while (m > 0) begin
            m = m >> 1;
            s++;
        end
        return s;
    endfunction

    task automatic push_word(input bit ac, input int comp, input int addr, input int size, input int val);
        logic [2:0]  map = 3'b110;
        logic [20:0] t;
        int          a;
        logic [31:0] w;
        t = tbl_f(ac, map[comp], 8'(addr));
        a = ((val >= 0) ? val : val - 1) & ((1 << size) - 1);
        w = (32'(t[15:0]) << size) | 32'(a);
        exp_q.push_back({1'b0, 6'(int'(t[20:16]) + size), w});
    endtask

    // Expected word stream for one block, straight from the JPEG symbol rules.
    task automatic model_block(input int comp, input int last, input bit eof);
        int v, diff, s, run;
        bit eob_done = 0;
        logic [38:0] tmp;
        v = int'(mem[0]);
        diff = v - pred_m[comp];
        pred_m[comp] = v;
        s = bitlen(diff < 0 ? -diff : diff);
        push_word(0, comp, s, s, diff);
        run = 0;
        for (int k = 1; k <= last; k++) begin
            v = int'(mem[k]);
            if (v == 0) begin
                if (k == last) begin
                    push_word(1, comp, 0, 0, 0);
                    eob_done = 1;
                end else begin
                    run++;
                end
            end else begin
                while (run > 15) begin
                    push_word(1, comp, 'hF0, 0, 0);
                    run -= 16;
                end
                s = bitlen(v < 0 ? -v : v);
                push_word(1, comp, (run << 4) | s, s, v);
                run = 0;
            end
        end
        if (!eob_done && last < 63) push_word(1, comp, 0, 0, 0);
        tmp = exp_q[exp_q.size() - 1];
        tmp[38] = eof;
        exp_q[exp_q.size() - 1] = tmp;
        if (eof) for (int i = 0; i < 3; i++) pred_m[i] = 0;
    endtask

    task automatic start_block(input int comp, input int last, input bit eof, output int base);
        model_block(comp, last, eof);
        base = got_q.size();
        comp_id = 2'(comp);
        max_idx = 6'(last);
        eof_in  = eof;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        comp_id = 2'(3 - comp);
        eof_in  = 1'b0;
    endtask

    task automatic finish_block(input string tag, input int base);
        int cyc = 0;
        int n_got, n_cmp;
        while (busy && cyc < 5000) begin
            tick();
            cyc++;
        end
        chk({tag, "_done"}, 64'(busy), 64'(0));
        n_got = got_q.size() - base;
        chk({tag, "_count"}, 64'(n_got), 64'(exp_q.size()));
        n_cmp = (n_got < exp_q.size()) ? n_got : exp_q.size();
        for (int i = 0; i < n_cmp; i++)
            chk($sformatf("%s_word%0d", tag, i), 64'(got_q[base + i]), 64'(exp_q[i]));
        exp_q.delete();
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 64; k++) mem[k] = '0;
    endtask

    function automatic logic signed [11:0] rand_coef();
        int sel = $urandom_range(0, 5);
        int m = $urandom_range(1, 15);
        case (sel)
            0: return -12'sd2048;
            1: return 12'sd2047;
            2: return 12'(m);
            3: return 12'(-m);
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, 64'({ram_rd, ram_addr, tbl_rd, tbl_ac, tbl_sel, tbl_addr, d_qual, eof_out, busy, d_len}), 64'(0));
        chk({tag, "_dout"}, 64'(d_out), 64'(0));
    endtask

    initial begin
        int base, cnt, a;
        logic [37:0] cap;
        for (int i = 0; i < 3; i++) pred_m[i] = 0;
        clear_mem();
        #1;
        chk_outputs_zero("reset");
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // DC = 5, last = 0: DC word then EOB, first d_qual 5 cycles after start
        mem[0] = 12'sd5;
        start_block(0, 0, 0, base);
        cnt = 1;
        while (!d_qual && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("first_qual_latency", 64'(cnt), 64'(5));
        finish_block("dc5", base);
        chk("dc5_sel", 64'(last_sel), 64'(0));

        // Same DC again: diff 0; then comp 1 DC = -3 on the chrominance table
        start_block(0, 0, 0, base);
        finish_block("dc_zero", base);
        mem[0] = -12'sd3;
        start_block(1, 0, 0, base);
        finish_block("dc_neg3", base);
        chk("comp1_sel", 64'(last_sel), 64'(1));

        // 20 zeros then 1 at idx 21: ZRL, 0x41, EOB
        clear_mem();
        mem[0]  = 12'sd5;
        mem[21] = 12'sd1;
        start_block(0, 21, 0, base);
        finish_block("zrl", base);

        // Nonzero at idx 63 with eof: no EOB, eof_out on last word, predictors cleared
        clear_mem();
        mem[0] = 12'sd100; mem[5] = -12'sd7; mem[40] = 12'sd300; mem[63] = 12'sd7;
        start_block(2, 63, 1, base);
        finish_block("last63_eof", base);
        mem[0] = 12'sd5;
        for (int c = 0; c < 3; c++) begin
            start_block(c, 0, 0, base);
            finish_block($sformatf("pred_cleared%0d", c), base);
        end

        // Output stall for 5 cycles, then zig_zag_halt for 3 cycles during READ
        clear_mem();
        mem[0] = 12'sd9; mem[1] = 12'sd3; mem[3] = -12'sd4;
        ready_force = 1'b0;
        start_block(2, 3, 0, base);
        cnt = 0;
        while (!d_qual && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("stall_qual", 64'(d_qual), 64'(1));
        cap = {d_len, d_out};
        repeat (5) begin
            tick();
            chk("stall_hold", 64'({d_qual, eof_out, d_len, d_out}), 64'({2'b10, cap}));
        end
        ready_force = 1'b1;
        cnt = 0;
        while (!ram_rd && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("halt_read_seen", 64'(ram_rd), 64'(1));
        a = int'(ram_addr);
        chk("halt_addr", 64'(a), 64'(1));
        halt_force = 1'b1;
        repeat (3) begin
            tick();
            chk("halt_hold", 64'({ram_rd, busy, ram_addr}), 64'({2'b01, 6'(a)}));
        end
        halt_force = 1'b0;
        finish_block("stall_halt", base);

        // Randomized blocks with random backpressure and halts
        ready_rand = 1'b1;
        halt_rand  = 1'b1;
        for (int b = 0; b < 40; b++) begin
            int comp = $urandom_range(0, 2);
            int last = ($urandom_range(0, 3) == 0) ? 63 : $urandom_range(0, 63);
            int dens = $urandom_range(1, 8);
            bit eof  = ($urandom_range(0, 7) == 0);
            clear_mem();
            mem[0] = 12'($urandom);
            for (int k = 1; k < 64; k++)
                if ($urandom_range(0, dens * 3) == 0) mem[k] = rand_coef();
            start_block(comp, last, eof, base);
            finish_block($sformatf("rand%0d", b), base);
        end
        ready_rand = 1'b0;
        halt_rand  = 1'b0;

        // Reset mid-block: outputs drop at once, next DC is coded against 0
        for (int k = 0; k < 64; k++) mem[k] = 12'(k + 1);
        start_block(1, 63, 0, base);
        repeat (9) tick();
        rst = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        exp_q.delete();
        for (int i = 0; i < 3; i++) pred_m[i] = 0;
        tick();
        rst = 1'b1;
        tick();
        clear_mem();
        mem[0] = -12'sd100;
        start_block(1, 0, 0, base);
        finish_block("after_reset", base);

`ifdef HUFF_RESTART_EN
        // restart_in while busy clears predictors once the block ends
        mem[0] = 12'sd40; mem[2] = 12'sd2;
        start_block(0, 2, 0, base);
        restart_in = 1'b1;
        tick();
        restart_in = 1'b0;
        finish_block("restart_busy", base);
        for (int i = 0; i < 3; i++) pred_m[i] = 0;
        clear_mem();
        mem[0] = 12'sd33;
        start_block(1, 0, 0, base);
        finish_block("restart_after", base);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
